xs3_stream_decoder: RTL
=======================

# xs3_stream_decoder

Receive-side decoder for the 4-bit excess-3 digit code used by our code-converter blocks. It accepts one excess-3 nibble per handshake and subtracts 3 to recover the BCD digit. Invalid codes are flagged. Digits are packed most-significant-first into a DIGITS-wide BCD word, which is presented on a registered valid/ready output with one word of buffering. It sits between the serial code-converter link and the BCD display/arithmetic datapath.

## Interface
- DIGITS, 4, BCD digits per output word (2..8).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_code/in_last valid this cycle.
- in_ready  output  1  decoder accepts input this cycle; transfer occurs when in_valid && in_ready.
- in_code  input  4  excess-3 code; valid range 4'h3..4'hC.
- in_last  input  1  the accepted digit ends the current word early.
- out_valid  output  1  out_bcd/out_count/out_err hold a complete word.
- out_ready  input  1  consumer takes the word when out_valid && out_ready.
- out_bcd  output  4*DIGITS  packed BCD; newest digit in bits [3:0].
- out_count  output  $clog2(DIGITS+1)  number of digits in the word (1..DIGITS).
- out_err  output  1  at least one digit in the word had an invalid code.

## Operation
- Digit decode: if in_code is in 3..12, digit = in_code − 3 (4-bit, no wrap). Otherwise digit = 4'h0 and the word's sticky error is set.
- Accumulator: acc (4*DIGITS bits), acc_cnt, acc_err.
- On each accept: acc = {acc[4*DIGITS-5:0], digit}, acc_cnt+1, acc_err |= invalid.
- Word completes on the accept where acc_cnt+1 == DIGITS, or where in_last = 1, whichever comes first.
- Partial words are right-aligned. Unused upper nibbles are 0.
- On completion the word moves to the output register if that register is free this cycle (out_valid == 0 || out_ready == 1). The accumulator then clears to zero, ready for the next word.
- States:
  - ACC: accepting digits; in_ready = 1.
    - A completing accept with the output register free loads it and stays in ACC.
    - A completing accept with the output register busy → HOLD. The completed word is kept in acc.
  - HOLD: in_ready = 0.
    - When the output register frees (out_ready && out_valid), acc loads into it, the accumulator clears, and the state returns to ACC.
- Output register: loads set out_valid = 1. A pop without a simultaneous load clears out_valid. A pop and a load in the same cycle keep out_valid = 1 with the new word.
- in_ready is a function of state only. It does not depend on in_valid or out_ready.

## Timing
- Reset (async assert, sync release):
  - state = ACC; acc, acc_cnt, acc_err = 0.
  - out_valid = 0, out_bcd = 0, out_count = 0, out_err = 0.
  - in_ready = 1 while in reset and after release.
- Latency: out_valid rises the cycle after the accept that completes a word.
- Throughput with out_ready held 1: one word per DIGITS accepts, with no input bubbles.
- HOLD costs at least one in_ready = 0 cycle. in_ready returns to 1 the cycle after the pop that drains the output register.
- Outputs stay stable while out_valid && !out_ready.
- Reset mid-word or in HOLD discards all partial and held data. No word is emitted.
- in_last on the DIGITS-th digit gives one normal full word, not an extra empty one.
- An invalid code on in_last is still counted: the digit becomes 0 and out_err = 1.
- Every flop is reset by rst_n. There are no combinational paths from in_* to out_*.

## Test plan
- Basic decode, DIGITS=4, out_ready=1:
  - Stimulus: codes 3,4,C,8 on consecutive cycles.
  - Required: the cycle after the 4th accept, out_valid=1, out_bcd=16'h0195, out_count=4, out_err=0.
- Partial word:
  - Stimulus: codes 7,5 with in_last on the second code.
  - Required: out_bcd=16'h0042, out_count=2, out_err=0. The next word starts empty.
- Invalid code:
  - Stimulus: codes 3,F,2,C.
  - Required: out_bcd=16'h0009, out_err=1.
  - Then the following word 4,4,4,4 gives 16'h1111 with out_err=0, proving the sticky error clears.
- Backpressure:
  - Stimulus: out_ready=0; two full words 4,5,6,7 and 8,9,A,B streamed.
  - Required: first word held at 16'h1234. After the 8th accept, in_ready=0 (HOLD).
  - Then raise out_ready for 1 cycle. Required: out_bcd=16'h5678 the next cycle, in_ready=1, no digit lost or duplicated.
- Reset mid-word:
  - Stimulus: accept 3,4, then pulse rst_n low for 1 cycle, then accept 5,6,7,8.
  - Required: all outputs 0 during reset. Next word is 16'h2345, count 4.
- Random stream vs reference model:
  - Stimulus: random in_valid, out_ready, in_last and codes over 10k cycles.
  - Required: word sequence, counts and error flags match the model exactly.

Source files
------------

// File: rtl/xs3_stream_decoder.sv
// xs3_stream_decoder: excess-3 nibble stream to packed BCD words.
// Digits are shifted in newest-last; a word completes after DIGITS digits
// or on in_last. A single output register holds the finished word; a second
// finished word waits in the accumulator (HOLD) until that register frees.
module xs3_stream_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [3:0]                   in_code_i,
    input  logic                         in_last_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [4*DIGITS-1:0]          out_bcd_o,
    output logic [$clog2(DIGITS+1)-1:0]  out_count_o,
    output logic                         out_err_o
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] acc_cnt_q, acc_cnt_d;
    logic          acc_err_q, acc_err_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_bcd_q, out_bcd_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          out_err_q, out_err_d;

    logic          code_ok;
    logic [3:0]    digit;
    logic          accept;
    logic          complete;
    logic          pop;
    logic          out_free;
    logic [W-1:0]  acc_shift;
    logic [CW-1:0] cnt_inc;
    logic          err_new;

    // Decode the incoming nibble and work out the handshake events
    always_comb begin
        code_ok   = (in_code_i >= 4'h3) && (in_code_i <= 4'hC);
        digit     = code_ok ? (in_code_i - 4'h3) : 4'h0;
        accept    = in_valid_i && (state_q == ST_ACC);
        acc_shift = {acc_q[W-5:0], digit};
        cnt_inc   = acc_cnt_q + 1'b1;
        err_new   = acc_err_q | ~code_ok;
        complete  = accept && ((cnt_inc == CW'(DIGITS)) || in_last_i);
        pop       = out_valid_q && out_ready_i;
        out_free  = !out_valid_q || out_ready_i;
    end

    // Next-state: accumulate digits, hand finished words to the output register
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        acc_err_d   = acc_err_q;
        out_bcd_d   = out_bcd_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;
        out_valid_d = pop ? 1'b0 : out_valid_q;

        if (state_q == ST_ACC) begin
            if (complete && out_free) begin
                out_valid_d = 1'b1;
                out_bcd_d   = acc_shift;
                out_count_d = cnt_inc;
                out_err_d   = err_new;
                acc_d       = '0;
                acc_cnt_d   = '0;
                acc_err_d   = 1'b0;
            end else if (accept) begin
                // A completed word that cannot move yet stays in acc
                acc_d     = acc_shift;
                acc_cnt_d = cnt_inc;
                acc_err_d = err_new;
                if (complete) begin
                    state_d = ST_HOLD;
                end
            end
        end else begin
            if (pop) begin
                out_valid_d = 1'b1;
                out_bcd_d   = acc_q;
                out_count_d = acc_cnt_q;
                out_err_d   = acc_err_q;
                acc_d       = '0;
                acc_cnt_d   = '0;
                acc_err_d   = 1'b0;
                state_d     = ST_ACC;
            end
        end
    end

    // State and datapath registers, all cleared by the async reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            acc_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_bcd_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_err_q   <= acc_err_d;
            out_valid_q <= out_valid_d;
            out_bcd_q   <= out_bcd_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready_o  = (state_q == ST_ACC);
    assign out_valid_o = out_valid_q;
    assign out_bcd_o   = out_bcd_q;
    assign out_count_o = out_count_q;
    assign out_err_o   = out_err_q;
endmodule
